// File: rtl/gpu_pkg.sv
// Shared definitions for the PC fetch controller: FSM states, opcodes and
// instruction field positions.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_UPDATE,
    ST_DONE
  } pc_ctrl_state_t;

  localparam logic [3:0] OP_BRNZP = 4'h1;
  localparam logic [3:0] OP_RET   = 4'hF;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned NZP_MSB    = 11;
  localparam int unsigned NZP_LSB    = 9;
  localparam int unsigned TARGET_MSB = 7;
  localparam int unsigned TARGET_LSB = 0;

endpackage

// File: rtl/pc_fetch_ctrl_decoder.sv
// instr_decoder: combinational classification of a fetched instruction into
// RET / BRnzp, with branch-taken evaluation against the execute-stage flags.
module instr_decoder
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instruction,
  input  logic [2:0]         nzp_flags,
  output logic               is_ret,
  output logic               is_branch,
  output logic               branch_taken,
  output logic [ADDR_W-1:0]  target
);

  logic [3:0] opcode;
  logic [2:0] nzp_mask;
  logic       unused_bits;

  // Bit 8 carries no meaning for the opcodes decoded here.
  assign unused_bits = instruction[8];

  // Field extraction and opcode classification.
  always_comb begin
    opcode       = instruction[OPCODE_MSB:OPCODE_LSB];
    nzp_mask     = instruction[NZP_MSB:NZP_LSB];
    is_ret       = (opcode == OP_RET);
    is_branch    = (opcode == OP_BRNZP);
    branch_taken = is_branch && (|(nzp_mask & nzp_flags));
    target       = ADDR_W'(instruction[TARGET_MSB:TARGET_LSB]);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch sequencer. Fetches at the current PC over
// a valid/ready handshake, decodes RET/BRnzp, issues other instructions to
// the execute stage and then steps or loads the PC.
// Optional build macro FETCH_TIMEOUT_EN adds a fetch watchdog that raises
// error and halts after TIMEOUT_CYCLES cycles without mem_read_ready.
module pc_fetch_ctrl
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned INSTR_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_write_enable,
  output logic               pc_increment,
  output logic [ADDR_W-1:0]  pc_target,
  output logic               mem_read_valid,
  output logic [ADDR_W-1:0]  mem_read_address,
  input  logic               mem_read_ready,
  input  logic [INSTR_W-1:0] mem_read_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  input  logic               exec_done,
  input  logic [2:0]         nzp_flags,
  output logic               busy,
  output logic               done,
  output logic               error
);

  pc_ctrl_state_t     state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               load_q, load_d;

  logic              dec_is_ret;
  logic              dec_is_branch;
  logic              dec_taken;
  logic [ADDR_W-1:0] dec_target;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  instr_decoder #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .instruction  (instr_q),
    .nzp_flags    (nzp_flags),
    .is_ret       (dec_is_ret),
    .is_branch    (dec_is_branch),
    .branch_taken (dec_taken),
    .target       (dec_target)
  );

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      target_q <= '0;
      load_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      target_q <= target_d;
      load_q   <= load_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      error_q  <= error_d;
`endif
    end
  end

  // Next-state logic; load_q selects PC load (taken branch) vs increment in UPDATE.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    target_d = target_q;
    load_d   = load_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = '0;
    error_d  = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          state_d = ST_DECODE;
        end
`ifdef FETCH_TIMEOUT_EN
        // Counter is held at zero outside FETCH, so it restarts on every entry.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DECODE: begin
        if (dec_is_ret) begin
          state_d = ST_DONE;
        end else if (dec_is_branch) begin
          load_d  = dec_taken;
          if (dec_taken) target_d = dec_target;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_done) begin
          load_d  = 1'b0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_FETCH;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    mem_read_valid   = (state_q == ST_FETCH);
    mem_read_address = (state_q == ST_FETCH) ? pc_value : '0;
    instr_valid      = (state_q == ST_ISSUE);
    pc_write_enable  = (state_q == ST_UPDATE) && load_q;
    pc_increment     = (state_q == ST_UPDATE) && !load_q;
    pc_target        = target_q;
    instruction      = instr_q;
    busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done             = (state_q == ST_DONE);
`ifdef FETCH_TIMEOUT_EN
    error            = error_q;
`else
    error            = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl with a behavioural program counter.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc_value;
  logic        pc_write_enable;
  logic        pc_increment;
  logic [7:0]  pc_target;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic        instr_valid;
  logic [15:0] instruction;
  logic        exec_done;
  logic [2:0]  nzp_flags;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int inc_cnt;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .ADDR_W         (8),
    .INSTR_W        (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .pc_value         (pc_value),
    .pc_write_enable  (pc_write_enable),
    .pc_increment     (pc_increment),
    .pc_target        (pc_target),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .instr_valid      (instr_valid),
    .instruction      (instruction),
    .exec_done        (exec_done),
    .nzp_flags        (nzp_flags),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  // Program counter driven by the controller's pulses.
  always @(posedge clk or posedge reset) begin
    if (reset)                pc_value <= 8'h00;
    else if (pc_write_enable) pc_value <= pc_target;
    else if (pc_increment)    pc_value <= pc_value + 8'h01;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, pc_write_enable, pc_increment, pc_target, mem_read_valid,
            mem_read_address, instr_valid, instruction, busy, done, error};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mem_read_ready = 1'b0; mem_read_data = '0;
    exec_done = 1'b0; nzp_flags = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Zero-wait non-branch instruction.
    mem_read_ready = 1'b1; mem_read_data = 16'h3000; exec_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("a_fetch_valid", {63'd0, mem_read_valid}, 64'd1);
    check("a_fetch_addr", {56'd0, mem_read_address}, 64'h00);
    check("a_fetch_busy", {63'd0, busy}, 64'd1);
    tick();
    check("a_dec_valid", {63'd0, mem_read_valid}, 64'd0);
    check("a_dec_instr", {48'd0, instruction}, 64'h3000);
    check("a_dec_ivalid", {63'd0, instr_valid}, 64'd0);
    tick();
    check("a_issue_ivalid", {63'd0, instr_valid}, 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_upd_ivalid", {63'd0, instr_valid}, 64'd0);
    check("a_upd_inc", {63'd0, pc_increment}, 64'd1);
    check("a_upd_we", {63'd0, pc_write_enable}, 64'd0);
    mem_read_ready = 1'b0;
    tick();

    // Memory ready after 5 wait cycles.
    for (int i = 0; i < 6; i++) begin
      check("b_hold_valid", {63'd0, mem_read_valid}, 64'd1);
      check("b_hold_addr", {56'd0, mem_read_address}, 64'h01);
      mem_read_ready = (i == 5);
      tick();
    end
    mem_read_ready = 1'b0;
    check("b_dec_valid", {63'd0, mem_read_valid}, 64'd0);
    inc_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      inc_cnt += int'(pc_increment);
      tick();
    end
    check("b_inc_count", 64'(inc_cnt), 64'd1);
    check("b_next_addr", {56'd0, mem_read_address}, 64'h02);

    // Taken branch.
    mem_read_data = 16'h1A40; nzp_flags = 3'b001; mem_read_ready = 1'b1;
    tick(); mem_read_ready = 1'b0;
    check("c_dec_ivalid", {63'd0, instr_valid}, 64'd0);
    tick();
    check("c_upd_we", {63'd0, pc_write_enable}, 64'd1);
    check("c_upd_inc", {63'd0, pc_increment}, 64'd0);
    check("c_upd_target", {56'd0, pc_target}, 64'h40);
    check("c_upd_ivalid", {63'd0, instr_valid}, 64'd0);
    tick();
    check("c_next_addr", {56'd0, mem_read_address}, 64'h40);

    // Not-taken branch.
    nzp_flags = 3'b010; mem_read_ready = 1'b1;
    tick(); mem_read_ready = 1'b0;
    tick();
    check("d_upd_inc", {63'd0, pc_increment}, 64'd1);
    check("d_upd_we", {63'd0, pc_write_enable}, 64'd0);
    check("d_target_hold", {56'd0, pc_target}, 64'h40);
    tick();
    check("d_next_addr", {56'd0, mem_read_address}, 64'h41);

    // Branch to 0xFF, then a slow-executing instruction wraps the PC.
    mem_read_data = 16'h1EFF; nzp_flags = 3'b001; mem_read_ready = 1'b1;
    tick(); mem_read_ready = 1'b0;
    tick(); tick();
    check("e_addr_ff", {56'd0, mem_read_address}, 64'hFF);
    mem_read_data = 16'h3000; exec_done = 1'b0; mem_read_ready = 1'b1;
    tick(); mem_read_ready = 1'b0;
    tick();
    check("e_issue_wait0", {63'd0, instr_valid}, 64'd1);
    tick();
    check("e_issue_wait1", {63'd0, instr_valid}, 64'd1);
    exec_done = 1'b1;
    tick();
    check("e_upd_inc", {63'd0, pc_increment}, 64'd1);
    tick();
    check("e_wrap_addr", {56'd0, mem_read_address}, 64'h00);
    check("e_no_flag", {62'd0, error, done}, 64'd0);

    // RET halts.
    mem_read_data = 16'hF000; mem_read_ready = 1'b1;
    tick(); mem_read_ready = 1'b0;
    check("f_dec_pulses", {62'd0, pc_write_enable, pc_increment}, 64'd0);
    tick();
    check("f_done", {63'd0, done}, 64'd1);
    check("f_busy", {63'd0, busy}, 64'd0);
    check("f_pulses", {62'd0, pc_write_enable, pc_increment}, 64'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("f_start_ignored", {61'd0, done, busy, mem_read_valid}, 64'b100);

    // Asynchronous reset in the middle of a fetch.
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("g_fetch_valid", {63'd0, mem_read_valid}, 64'd1);
    #2 reset = 1'b1;
    #1 check("g_async_outs", all_outs(), 64'd0);
    mem_read_ready = 1'b1; mem_read_data = 16'h3000;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("g_not_consumed", {47'd0, busy, instruction}, 64'd0);
    mem_read_ready = 1'b0;

    // Fetch with memory never ready.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("h_last_valid", {63'd0, mem_read_valid}, 64'd1);
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    check("h_error", {63'd0, error}, 64'd1);
    check("h_done", {63'd0, done}, 64'd1);
    check("h_valid", {63'd0, mem_read_valid}, 64'd0);
`else
    check("h_no_error", {63'd0, error}, 64'd0);
    check("h_still_fetch", {62'd0, busy, mem_read_valid}, 64'b11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Per-core instruction-fetch sequencer that drives the 8-bit program counter's write-enable and increment controls. It fetches the instruction at the current PC over a valid/ready memory handshake and decodes the branch and halt opcodes. It hands each other instruction to the execute stage and, after completion, steps or loads the PC. It sits between the program counter, the instruction memory port and the core's execute stage.

Parameters:
ADDR_W, 8, PC and instruction-address width.
INSTR_W, 16, instruction width.
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins fetching from the current PC
pc_value  in  ADDR_W  current PC output
pc_write_enable  out  1  one-cycle pulse; PC loads pc_target
pc_increment  out  1  one-cycle pulse; PC increments by 1
pc_target  out  ADDR_W  branch target address
mem_read_valid  out  1  instruction read request
mem_read_address  out  ADDR_W  instruction address
mem_read_ready  in  1  memory returns data this cycle
mem_read_data  in  INSTR_W  instruction word
instr_valid  out  1  instruction presented to execute stage
instruction  out  INSTR_W  latched instruction
exec_done  in  1  execute stage finished the presented instruction
nzp_flags  in  3  condition flags {n,z,p} from execute stage
busy  out  1  controller not in IDLE or DONE
done  out  1  high in DONE (core halted)
error  out  1  fetch timeout; always 0 unless FETCH_TIMEOUT_EN

Behaviour:
- Reset (async): state=IDLE; every output 0; instruction register 0.
- States: IDLE, FETCH, DECODE, ISSUE, UPDATE, DONE.
- IDLE: if start=1, go to FETCH next cycle. All other inputs are ignored.
- FETCH: mem_read_valid=1 and mem_read_address=pc_value, held stable until mem_read_ready=1.
  - On ready, latch mem_read_data into instruction, deassert valid the next cycle and go to DECODE.
  - If ready arrives in the first FETCH cycle, FETCH lasts exactly 1 cycle.
- DECODE (1 cycle), opcode = instruction[15:12]:
  - 4'hF (RET): go to DONE.
  - 4'h1 (BRnzp): taken = |(instruction[11:9] & nzp_flags). Go to UPDATE with pc_target=instruction[7:0] if taken. If not taken, go to UPDATE as an increment.
  - Any other opcode: go to ISSUE.
- ISSUE: instr_valid=1 until exec_done=1 is sampled, then go to UPDATE (increment). If exec_done is high on the first ISSUE cycle, ISSUE lasts 1 cycle.
- UPDATE (1 cycle): exactly one of pc_write_enable or pc_increment is 1, never both. Next state is FETCH.
- Latency for a non-branch instruction with zero-wait memory and immediate exec_done: FETCH 1 + DECODE 1 + ISSUE 1 + UPDATE 1 = 4 cycles per instruction.
- Branch latency: 3 cycles (no ISSUE).
- DONE: done=1, busy=0. Stays in DONE until reset; start is ignored.
- pc_value=8'hFF with increment: the PC wraps to 8'h00 and fetching continues. No flag is raised.
- start asserted while busy: ignored.
- Reset mid-handshake: mem_read_valid drops immediately (async). The pending memory response is not consumed afterwards.
- pc_target holds its last value outside branch UPDATE cycles.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) clears on FETCH entry and counts each FETCH cycle without mem_read_ready.
  - On reaching TIMEOUT_CYCLES: error=1, mem_read_valid=0, go to DONE. error stays high until reset.
- Undefined: no counter is built, error is tied to 0, and FETCH waits indefinitely.

Decomposition:
- Shared package gpu_pkg holds:
  - state enum pc_ctrl_state_t;
  - opcode constants OP_BRNZP=4'h1 and OP_RET=4'hF;
  - field-position localparams (opcode [15:12], nzp [11:9], target [7:0]).
- Natural sub-module: instr_decoder, a combinational block. Inputs: instruction, nzp_flags. Outputs: is_ret, is_branch, branch_taken, target.

Test Plan:
- Reset, then start. Memory ready immediately with 16'h3000, exec_done on first ISSUE cycle -> mem_read_address=0; instr_valid for 1 cycle; pc_increment pulse 4 cycles after FETCH entry.
- Memory ready delayed 5 cycles -> mem_read_valid=1 and address stable for 6 cycles; exactly one increment pulse follows.
- BRnzp 16'h1A40 (nzp=3'b101) with nzp_flags=3'b001 -> pc_write_enable pulse, pc_target=8'h40, instr_valid never asserted.
- Same branch with nzp_flags=3'b010 -> pc_increment pulse only.
- Fetch returns 16'hF000 -> done=1, busy=0; no PC pulse; a later start is ignored.
- Reset asserted during FETCH -> all outputs 0 in the same cycle. With FETCH_TIMEOUT_EN and ready held low for 64 cycles -> error=1, done=1.
